// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary matrix-multiply array: weight
// encodings, the weight decoder and the readout state type.
package ternary_pkg;

   localparam int ACT_W = 8;
   localparam int OUT_W = 8;

   localparam logic [1:0] T_ZERO = 2'b00;
   localparam logic [1:0] T_POS  = 2'b01;
   localparam logic [1:0] T_NEG  = 2'b10;

   // zero: weight contributes nothing; sign: weight is -1 (subtract)
   typedef struct packed {
      logic zero;
      logic sign;
   } tdec_t;

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_ACTIVE = 1'b1
   } rd_state_t;

   // Both 10 and 11 decode to -1; only 00 is a zero weight.
   function automatic tdec_t t_decode(input logic [1:0] code);
      tdec_t d;
      d.zero = (code == T_ZERO);
      d.sign = (code == T_NEG) || (code == 2'b11);
      return d;
   endfunction

endpackage

// File: rtl/ternary_pe.sv
// One processing element: a signed wrapping accumulator that adds,
// subtracts or ignores a sign-extended activation according to a
// ternary weight. acc_next exposes the value the register will take so
// a snapshot can include a MAC happening in the same cycle.
module ternary_pe
   import ternary_pkg::*;
#(
   parameter int ACC_W = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mac_en,
   input  logic             clr,
   input  logic [1:0]       w,
   input  logic [ACT_W-1:0] act,
   output logic [ACC_W-1:0] acc_next
);

   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] term_s;
   tdec_t            dec_s;

   // Sign-extend the activation and pick add, subtract or hold.
   always_comb begin
      dec_s  = t_decode(w);
      term_s = {{(ACC_W-ACT_W){act[ACT_W-1]}}, act};
      if (mac_en && !dec_s.zero) begin
         if (dec_s.sign) begin
            acc_next = acc_r - term_s;
         end else begin
            acc_next = acc_r + term_s;
         end
      end else begin
         acc_next = acc_r;
      end
   end

   // Accumulator register; a flush clears it even if a MAC is pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (clr) begin
         acc_r <= {ACC_W{1'b0}};
      end else begin
         acc_r <= acc_next;
      end
   end

endmodule

// File: rtl/ternary_matmul_array.sv
// Ternary matrix-multiply array. Input beats fill a staging area one
// slice at a time; the last slice of a group commits everything to the
// operand registers and triggers one parallel MAC across all cells.
// A flush snapshots the accumulators into a readout queue, clears them
// and streams the post-processed words out under valid/ready.
module ternary_matmul_array
   import ternary_pkg::*;
#(
   parameter int LANES = 4,
   parameter int SLICES = 2,
   parameter int ACC_W = 17
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [2*LANES-1:0] in_weights,
   input  logic [ACT_W-1:0]   in_act,
   input  logic               flush,
   input  logic [2:0]         cfg_shift,
   input  logic               cfg_relu,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_last
);

   localparam int ROWS  = LANES * SLICES;
   localparam int COLS  = SLICES;
   localparam int CELLS = ROWS * COLS;
   localparam int SC_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

   // ------------------------------------------------------------------
   // Input staging
   // ------------------------------------------------------------------
   logic [SC_W-1:0]  slice_cnt_r;
   logic             beat_s;
   logic             last_slice_s;
   logic             commit_s;

   logic [1:0]       stg_w_r      [ROWS];
   logic [ACT_W-1:0] stg_a_r      [COLS];
   logic [1:0]       stg_w_next_s [ROWS];
   logic [ACT_W-1:0] stg_a_next_s [COLS];

   logic [1:0]       op_w_r [ROWS];
   logic [ACT_W-1:0] op_a_r [COLS];
   logic             mac_pending_r;

   // A beat colliding with flush is dropped entirely.
   always_comb begin
      beat_s       = in_valid && !flush;
      last_slice_s = (slice_cnt_r == SC_W'(SLICES - 1));
      commit_s     = beat_s && last_slice_s;
   end

   // Merge the current beat into the staging image so a commit sees it.
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         if (beat_s && (SC_W'(r / LANES) == slice_cnt_r)) begin
            stg_w_next_s[r] = in_weights[2*(r % LANES) +: 2];
         end else begin
            stg_w_next_s[r] = stg_w_r[r];
         end
      end
      for (int c = 0; c < COLS; c++) begin
         if (beat_s && (SC_W'(c) == slice_cnt_r)) begin
            stg_a_next_s[c] = in_act;
         end else begin
            stg_a_next_s[c] = stg_a_r[c];
         end
      end
   end

   // Slice counter: advances per accepted beat, wraps per group, cleared by flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slice_cnt_r <= {SC_W{1'b0}};
      end else if (flush) begin
         slice_cnt_r <= {SC_W{1'b0}};
      end else if (beat_s) begin
         if (last_slice_s) begin
            slice_cnt_r <= {SC_W{1'b0}};
         end else begin
            slice_cnt_r <= slice_cnt_r + SC_W'(1);
         end
      end else begin
         slice_cnt_r <= slice_cnt_r;
      end
   end

   // Staging registers hold partial groups; flush deliberately leaves them alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < ROWS; r++) stg_w_r[r] <= 2'b00;
         for (int c = 0; c < COLS; c++) stg_a_r[c] <= {ACT_W{1'b0}};
      end else begin
         stg_w_r <= stg_w_next_s;
         stg_a_r <= stg_a_next_s;
      end
   end

   // Operand registers load a complete group and arm the MAC for the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < ROWS; r++) op_w_r[r] <= 2'b00;
         for (int c = 0; c < COLS; c++) op_a_r[c] <= {ACT_W{1'b0}};
         mac_pending_r <= 1'b0;
      end else begin
         if (commit_s) begin
            op_w_r <= stg_w_next_s;
            op_a_r <= stg_a_next_s;
         end else begin
            op_w_r <= op_w_r;
            op_a_r <= op_a_r;
         end
         mac_pending_r <= commit_s;
      end
   end

   // ------------------------------------------------------------------
   // Processing-element grid
   // ------------------------------------------------------------------
   logic [ACC_W-1:0] acc_next_s [CELLS];

   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < COLS; gc++) begin : g_col
         ternary_pe #(
            .ACC_W (ACC_W)
         ) u_pe (
            .clk      (clk),
            .rst_n    (rst_n),
            .mac_en   (mac_pending_r),
            .clr      (flush),
            .w        (op_w_r[gr]),
            .act      (op_a_r[gc]),
            .acc_next (acc_next_s[gr*COLS + gc])
         );
      end
   end

   // ------------------------------------------------------------------
   // Snapshot queue and readout
   // ------------------------------------------------------------------
   logic [ACC_W-1:0] q_r [CELLS];
   logic [IDX_W-1:0] rd_idx_r;
   rd_state_t        rd_state_r;
   logic             out_valid_r;
   logic             out_last_r;

   // Snapshot captures acc_next so a MAC in the flush cycle is included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CELLS; i++) q_r[i] <= {ACC_W{1'b0}};
      end else if (flush) begin
         q_r <= acc_next_s;
      end else begin
         q_r <= q_r;
      end
   end

   // Readout FSM: flush (re)starts at word 0; the final accepted word ends it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_r  <= RD_IDLE;
         rd_idx_r    <= {IDX_W{1'b0}};
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else if (flush) begin
         rd_state_r  <= RD_ACTIVE;
         rd_idx_r    <= {IDX_W{1'b0}};
         out_valid_r <= 1'b1;
         out_last_r  <= (CELLS == 1);
      end else begin
         case (rd_state_r)
            RD_ACTIVE: begin
               if (out_ready) begin
                  if (rd_idx_r == IDX_W'(CELLS - 1)) begin
                     rd_state_r  <= RD_IDLE;
                     rd_idx_r    <= {IDX_W{1'b0}};
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                  end else begin
                     rd_state_r  <= RD_ACTIVE;
                     rd_idx_r    <= rd_idx_r + IDX_W'(1);
                     out_valid_r <= 1'b1;
                     out_last_r  <= ((rd_idx_r + IDX_W'(1)) == IDX_W'(CELLS - 1));
                  end
               end else begin
                  rd_state_r  <= rd_state_r;
                  rd_idx_r    <= rd_idx_r;
                  out_valid_r <= out_valid_r;
                  out_last_r  <= out_last_r;
               end
            end
            RD_IDLE: begin
               rd_state_r  <= RD_IDLE;
               rd_idx_r    <= rd_idx_r;
               out_valid_r <= 1'b0;
               out_last_r  <= 1'b0;
            end
            default: begin
               rd_state_r  <= RD_IDLE;
               rd_idx_r    <= {IDX_W{1'b0}};
               out_valid_r <= 1'b0;
               out_last_r  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output post-processing: shift, optional ReLU, saturate to 8 bits
   // ------------------------------------------------------------------
   logic [ACC_W-1:0] sel_s;
   logic [ACC_W-1:0] shf_s;
   logic [ACC_W-1:0] rel_s;
   logic [OUT_W-1:0] sat_s;
   logic             fits_s;

   // Post-processing follows the live cfg inputs, so the word is combinational.
   always_comb begin
      sel_s = q_r[rd_idx_r];
      shf_s = ACC_W'($signed(sel_s) >>> cfg_shift);
      if (cfg_relu && shf_s[ACC_W-1]) begin
         rel_s = {ACC_W{1'b0}};
      end else begin
         rel_s = shf_s;
      end
      // In range exactly when every bit above the output sign bit matches it.
      fits_s = (&rel_s[ACC_W-1:OUT_W-1]) || !(|rel_s[ACC_W-1:OUT_W-1]);
      if (fits_s) begin
         sat_s = rel_s[OUT_W-1:0];
      end else if (rel_s[ACC_W-1]) begin
         sat_s = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         sat_s = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign out_data  = sat_s;

endmodule

// File: doc/ternary_matmul_array.md
TERNARY_MATMUL_ARRAY -- requirements
Module: ternary_matmul_array

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  LANES, 4, ternary weights per input beat.
  SLICES, 2, beats per operand group; also the number of columns.
  ACC_W, 17, accumulator width in bits (signed).
  ROWS = LANES*SLICES and COLS = SLICES are derived, not overridable.
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  in_valid  in  1  input beat present; there is no input backpressure.
  in_weights  in  2*LANES  packed ternary weights; lane k uses bits [2k+1:2k].
  in_act  in  8  signed activation for column slice_cnt.
  flush  in  1  single-cycle pulse: snapshot accumulators, clear them, start readout.
  cfg_shift  in  3  arithmetic right shift applied at output.
  cfg_relu  in  1  clamp negative outputs to 0.
  out_valid  out  1  out_data holds a valid word.
  out_ready  in  1  downstream accepts the word.
  out_data  out  8  signed post-processed result.
  out_last  out  1  high with the final word of a readout.

Function
REQ-003 Ternary decode: 00 = 0; 01 = +1; 10 and 11 = -1.
REQ-004 slice_cnt (0..SLICES-1) increments on each accepted beat (in_valid high, flush low) and wraps to 0 after SLICES-1.
REQ-005 A beat at slice k writes its lanes to staging weight rows k*LANES..k*LANES+LANES-1 and writes in_act to staging activation column k.
REQ-006 On the beat at slice SLICES-1, that beat's data and all earlier staging contents commit to the operand registers, and mac_pending is set for the next cycle.
REQ-007 In the cycle that mac_pending is high, every cell updates in parallel: acc[r][c] += w[r]*act[c]. Latency is 1 cycle from the committing beat.
REQ-008 Accumulators are signed ACC_W bits and wrap modulo 2^ACC_W. Activations are sign-extended before the add.
REQ-009 On flush:
  - the queue captures acc_next, so an in-flight MAC is included;
  - accumulators clear to 0;
  - slice_cnt clears to 0;
  - the staging registers are not cleared;
  - read index clears to 0;
  - out_valid is set the next cycle.
REQ-010 A beat presented in the same cycle as flush is discarded.
REQ-011 Readout order is index r*COLS+c, from 0 to ROWS*COLS-1. The index advances only on out_valid && out_ready.
REQ-012 out_data is computed in this order:
  - q >>> cfg_shift;
  - if cfg_relu, negatives become 0;
  - saturate to [-128, 127].
  The result is combinational from the queue entry and the current cfg.
REQ-013 out_data is stable while out_valid is high and out_ready is low.
REQ-014 out_last is high with index ROWS*COLS-1. Acceptance of that word clears out_valid.
REQ-015 A flush during readout discards the remaining words and restarts readout on a fresh snapshot.
REQ-016 Accumulation continues freely during readout.

Reset
REQ-017 While rst_n is low, all of the following clear to 0: slice_cnt, mac_pending, staging, operand registers, accumulators, queue, read index, out_valid, out_last.
REQ-018 Reset mid-readout aborts the readout immediately. No word is emitted until the next flush.

Structure
REQ-019 Package ternary_pkg holds:
  - the 2-bit encoding constants (T_ZERO, T_POS, T_NEG);
  - a decode function returning {zero, sign}.
REQ-020 The per-cell accumulator and its conditional add/subtract are implemented as sub-module ternary_pe, instantiated ROWS*COLS times.

Verification
REQ-021 Default parameters are used throughout. Directed scenarios:
  - Reset: after rst_n is released -> out_valid=0 and out_last=0; an immediate flush then reads 16 zeros.
  - Basic group:
      - stimulus: beat0 weights 0x55 with act 3; beat1 weights 0xAA with act 5; flush 2 cycles later; shift 0, relu 0.
      - required output: 3,5 four times, then -3,-5 four times; out_last on word 15.
  - Post-processing: three groups of all-+1 weights with act 127 (acc 381):
      - shift 0 -> 127;
      - shift 2 -> 95;
      - all -1 weights with relu=1 -> 0.
  - Backpressure: hold out_ready low for 5 cycles mid-readout -> out_data and the index are unchanged; no word is lost or duplicated.
  - Flush collision: flush coincides with beat0 of a group -> the beat is dropped; a subsequent group uses slice 0 correctly; the in-flight MAC appears in the snapshot.
  - Async reset after word 6 of a readout -> out_valid falls without waiting for clk; all later reads are 0 until a new group is accumulated.
